// File: rtl/mul_unit_64_if.sv
// rtl/mul_unit_64_if.sv - request/response bundle for the 64-bit sequential multiplier
interface mul_unit_64_if;
  logic        i_start;
  logic        i_flush;
  logic [1:0]  i_op;
  logic [63:0] i_rs1;
  logic [63:0] i_rs2;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_result;

  modport master (
    output i_start, i_flush, i_op, i_rs1, i_rs2,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_flush, i_op, i_rs1, i_rs2,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/mul_unit_64.sv
// rtl/mul_unit_64.sv - radix-2 shift-add 64x64 multiplier with MUL/MULH/MULHSU/MULHU
module mul_unit_64 (
  input  logic          i_clk,
  input  logic          i_reset,
  mul_unit_64_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b11;

  state_t       state;
  logic [63:0]  mcand;
  logic [63:0]  mplier;
  logic [127:0] acc;
  logic [5:0]   cnt;
  logic         neg;
  logic [1:0]   op_q;
  logic         busy;
  logic         done;
  logic [63:0]  result;

  logic         rs1_neg;
  logic         rs2_neg;
  logic [63:0]  mag1;
  logic [63:0]  mag2;
  logic [64:0]  sum;
  logic [127:0] fixed;

  // Operand magnitudes and sign; negating -2^63 in 64 bits yields 2^63 unsigned.
  always_comb begin
    rs1_neg = (bus.i_op != OP_MULU) && bus.i_rs1[63];
    rs2_neg = (bus.i_op[1] == 1'b0) && bus.i_rs2[63];
    mag1    = rs1_neg ? (~bus.i_rs1 + 64'd1) : bus.i_rs1;
    mag2    = rs2_neg ? (~bus.i_rs2 + 64'd1) : bus.i_rs2;
    sum     = {1'b0, acc[127:64]} + {1'b0, (mplier[0] ? mcand : 64'd0)};
    fixed   = neg ? (~acc + 128'd1) : acc;
  end

  // Control FSM with registered busy/done/result and the shift-add datapath.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 64'd0;
      acc    <= 128'd0;
      cnt    <= 6'd0;
      mcand  <= 64'd0;
      mplier <= 64'd0;
      neg    <= 1'b0;
      op_q   <= OP_MUL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_flush) begin
            mcand  <= mag1;
            mplier <= mag2;
            neg    <= rs1_neg ^ rs2_neg;
            op_q   <= bus.i_op;
            acc    <= 128'd0;
            cnt    <= 6'd0;
            busy   <= 1'b1;
            state  <= ITER;
          end
        end
        ITER: begin
          if (bus.i_flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc    <= {sum, acc[63:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.i_flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result <= (op_q == OP_MUL) ? fixed[63:0] : fixed[127:64];
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy   = busy;
  assign bus.o_done   = done;
  assign bus.o_result = result;

endmodule

// File: tb/tb_mul_unit_64.sv
// tb/tb_mul_unit_64.sv - directed-vector bench for mul_unit_64
module tb_mul_unit_64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  mul_unit_64_if bus ();

  mul_unit_64 dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Drives a request at a negedge, returns at the negedge after the start edge
  // with operands/op scrambled so that busy-time changes are exercised.
  task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.i_op    = op;
    bus.i_rs1   = a;
    bus.i_rs2   = b;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_op    = ~op;
    bus.i_rs1   = ~a;
    bus.i_rs2   = a ^ b ^ 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  // Starting at the negedge after the start edge, counts edges until o_done.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (edges < 300) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) break;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    int e, bc;
    @(negedge clk);
    vec_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 64'd0) begin
      err_cnt++;
      $display("FAIL reset_state busy=%b done=%b result=%h expected 0/0/0", bus.o_busy, bus.o_done, bus.o_result);
    end
    rst = 1'b0;
    start_op(2'b00, 64'd2, 64'd3);
    vec_cnt++;
    if (bus.o_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL first_start_after_reset busy=%b expected 1", bus.o_busy);
    end
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd6 || e != 65) begin
      err_cnt++;
      $display("FAIL mul_2x3 result=%h edges=%0d expected 6 edges=65", bus.o_result, e);
    end
  endtask

  task automatic test_mul;
    int e, bc;
    @(negedge clk);
    start_op(2'b00, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      err_cnt++;
      $display("FAIL mul_3xm5 result=%h expected fffffffffffffff1", bus.o_result);
    end
    vec_cnt++;
    if (e != 65) begin
      err_cnt++;
      $display("FAIL mul_latency edges=%0d expected 65", e);
    end
    @(negedge clk);
    if (bus.o_busy) bc++;
    vec_cnt++;
    if (bc != 66 || bus.o_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL busy_cycles busy=%0d done_after=%b expected 66 and 0", bc, bus.o_done);
    end
  endtask

  task automatic test_mulh;
    int e, bc;
    @(negedge clk);
    start_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'h4000_0000_0000_0000 || e != 65) begin
      err_cnt++;
      $display("FAIL mulh_min result=%h edges=%0d expected 4000000000000000 65", bus.o_result, e);
    end
  endtask

  task automatic test_mulhu;
    int e, bc;
    @(negedge clk);
    start_op(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      err_cnt++;
      $display("FAIL mulhu_max result=%h expected fffffffffffffffe", bus.o_result);
    end
    @(negedge clk);
    start_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd1) begin
      err_cnt++;
      $display("FAIL mul_m1xm1 result=%h expected 1", bus.o_result);
    end
  endtask

  task automatic test_mulhsu;
    int e, bc;
    @(negedge clk);
    start_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      err_cnt++;
      $display("FAIL mulhsu_m1 result=%h expected ffffffffffffffff", bus.o_result);
    end
    @(negedge clk);
    start_op(2'b10, 64'h0000_0000_0000_0002, 64'h8000_0000_0000_0000);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd1) begin
      err_cnt++;
      $display("FAIL mulhsu_2x2p63 result=%h expected 1", bus.o_result);
    end
  endtask

  task automatic test_flush;
    int e, bc, d;
    logic [63:0] prior;
    prior = bus.o_result;
    @(negedge clk);
    start_op(2'b00, 64'd7, 64'd6);
    for (int i = 0; i < 10; i++) @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_start = 1'b0;
    vec_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== prior) begin
      err_cnt++;
      $display("FAIL flush_iter busy=%b done=%b result=%h expected 0 0 %h", bus.o_busy, bus.o_done, bus.o_result, prior);
    end
    d = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.o_done) d++;
    end
    vec_cnt++;
    if (d != 0) begin
      err_cnt++;
      $display("FAIL flush_no_done strobes=%0d expected 0", d);
    end
    start_op(2'b00, 64'd5, 64'd5);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd25 || e != 65) begin
      err_cnt++;
      $display("FAIL after_flush_5x5 result=%h edges=%0d expected 19 65", bus.o_result, e);
    end
  endtask

  task automatic test_flush_start_idle;
    @(negedge clk);
    @(negedge clk);
    bus.i_op    = 2'b00;
    bus.i_rs1   = 64'd9;
    bus.i_rs2   = 64'd9;
    bus.i_start = 1'b1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    vec_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_result !== 64'd25) begin
      err_cnt++;
      $display("FAIL flush_with_start busy=%b result=%h expected 0 19", bus.o_busy, bus.o_result);
    end
  endtask

  task automatic test_back_to_back;
    int e, bc;
    @(negedge clk);
    start_op(2'b00, 64'd4, 64'd4);
    wait_done(e, bc);
    bus.i_op    = 2'b00;
    bus.i_rs1   = 64'd8;
    bus.i_rs2   = 64'd9;
    bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_result !== 64'd16) begin
      err_cnt++;
      $display("FAIL start_in_done busy=%b result=%h expected 0 10", bus.o_busy, bus.o_result);
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd72 || e != 65) begin
      err_cnt++;
      $display("FAIL back_to_back result=%h edges=%0d expected 48 65", bus.o_result, e);
    end
  endtask

  task automatic test_flush_in_done;
    int e, bc;
    @(negedge clk);
    start_op(2'b00, 64'd11, 64'd13);
    wait_done(e, bc);
    bus.i_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b0;
    vec_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_result !== 64'd143 || e != 65) begin
      err_cnt++;
      $display("FAIL flush_in_done busy=%b result=%h edges=%0d expected 0 8f 65", bus.o_busy, bus.o_result, e);
    end
  endtask

  task automatic test_zero;
    int e, bc;
    @(negedge clk);
    start_op(2'b11, 64'd0, 64'h1234_5678_9ABC_DEF0);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'd0 || e != 65) begin
      err_cnt++;
      $display("FAIL zero_operand result=%h edges=%0d expected 0 65", bus.o_result, e);
    end
  endtask

  task automatic test_reset_mid_iter;
    int e, bc, d;
    @(negedge clk);
    start_op(2'b00, 64'd6, 64'd7);
    wait_done(e, bc);
    vec_cnt++;
    if (bus.o_result !== 64'h2A) begin
      err_cnt++;
      $display("FAIL pre_reset_6x7 result=%h expected 2a", bus.o_result);
    end
    @(negedge clk);
    start_op(2'b00, 64'd9, 64'd9);
    for (int i = 0; i < 30; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (bus.o_result !== 64'd0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_iter result=%h busy=%b done=%b expected 0 0 0", bus.o_result, bus.o_busy, bus.o_done);
    end
    @(negedge clk);
    rst = 1'b0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_done) d++;
    end
    vec_cnt++;
    if (d != 0 || bus.o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_no_done strobes=%0d busy=%b expected 0 0", d, bus.o_busy);
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_rs1   = 64'd0;
    bus.i_rs2   = 64'd0;
    test_reset();
    test_mul();
    test_mulh();
    test_mulhu();
    test_mulhsu();
    test_zero();
    test_flush();
    test_flush_start_idle();
    test_back_to_back();
    test_flush_in_done();
    test_reset_mid_iter();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mul_unit_64.md
MUL_UNIT_64 -- requirements
Module: mul_unit_64

Interface
REQ-001 Parameters: none; datapath width fixed at 64 bits.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_reset  input  1  reset, asynchronous and active-high.
REQ-004 i_start  input  1  request pulse; sampled only in IDLE.
REQ-005 i_flush  input  1  synchronous abort of an in-flight operation.
REQ-006 i_op  input  2  00 MUL (low 64), 01 MULH (s x s, high), 10 MULHSU (s x u, high), 11 MULHU (u x u, high).
REQ-007 i_rs1  input  64  multiplicand.
REQ-008 i_rs2  input  64  multiplier.
REQ-009 o_busy  output  1  high whenever state != IDLE.
REQ-010 o_done  output  1  one-cycle completion strobe.
REQ-011 o_result  output  64  registered result; feeds write-back select mux data input.

Function
REQ-012 FSM states SHALL be IDLE, ITER, FIX, DONE; reset state IDLE.
REQ-013 IDLE: on edge with i_start=1 and i_flush=0, capture |rs1|, |rs2| as 64-bit unsigned magnitudes, result sign, op; clear 128-bit accumulator and 6-bit counter; go ITER.
REQ-014 Signedness: rs1 signed for MUL/MULH/MULHSU; rs2 signed for MUL/MULH only; unsigned operands taken as-is.
REQ-015 Magnitude of -2^63 SHALL be 0x8000_0000_0000_0000 (no overflow, unsigned 64-bit).
REQ-016 ITER: one radix-2 shift-add step per edge (LSB of multiplier selects add of multiplicand into upper accumulator half, then shift right 1); exactly 64 steps; counter 63 -> FIX.
REQ-017 FIX: negate 128-bit product (two's complement) if sign flag set; load o_result with low 64 bits for MUL, high 64 bits otherwise; go DONE.
REQ-018 DONE: o_done=1 for exactly this cycle; next edge -> IDLE unconditionally.
REQ-019 Latency: o_done high in the cycle following the 65th rising edge after the edge that sampled i_start (1 capture + 64 ITER + FIX).
REQ-020 Back-to-back: i_start in DONE SHALL be ignored; earliest accepted restart is the first IDLE cycle.
REQ-021 i_start while ITER/FIX/DONE SHALL be ignored; operands and op changing during busy SHALL not affect the result.
REQ-022 i_flush=1 in ITER or FIX: next state IDLE, o_done not asserted, o_result unchanged.
REQ-023 i_flush=1 coincident with i_start in IDLE: request dropped, remain IDLE.
REQ-024 i_flush in DONE: no effect (strobe already issued).
REQ-025 o_result SHALL hold its value until the next FIX-state load; never updated by flushed operations.
REQ-026 Zero operands SHALL take full latency (no early-out).

Reset
REQ-027 i_reset asserted (any time, including mid-ITER) SHALL immediately force state IDLE, o_busy=0, o_done=0, o_result=0, accumulator and counter 0.
REQ-028 Operation interrupted by reset SHALL produce no o_done after reset release.
REQ-029 First i_start accepted on the first rising edge with i_reset low.

Verification
REQ-030 MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB (-5) -> o_result=0xFFFF_FFFF_FFFF_FFF1, o_done exactly 65 edges after start edge, o_busy high 66 cycles.
REQ-031 MULH rs1=rs2=0x8000_0000_0000_0000 -> o_result=0x4000_0000_0000_0000.
REQ-032 MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> o_result=0xFFFF_FFFF_FFFF_FFFE; same operands MUL -> 0x0000_0000_0000_0001.
REQ-033 MULHSU rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=0xFFFF_FFFF_FFFF_FFFF (unsigned) -> o_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-034 Start MUL 7x6, pulse i_flush at ITER step 10, re-pulse i_start during busy -> no o_done, IDLE next cycle, o_result keeps prior value; new start 5x5 -> 25 after 65 edges.
REQ-035 Assert i_reset at ITER step 30 of a prior result 0x2A -> o_result=0, o_busy=0 immediately, no o_done within 100 cycles after release.
